// File: rtl/fir_seq_feeder.sv
// fir_seq_feeder: serial coefficient loader and one-at-a-time sample issuer for a sequential FIR.
// Optional zero-sample flush is built only when FIR_FEED_FLUSH_EN is defined.
module fir_seq_feeder #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int ORDER         = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_req_i,
  input  logic                        coef_valid_i,
  output logic                        coef_ready_o,
  input  logic [COEF_WIDTH-1:0]       coef_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [DATA_IN_WIDTH-1:0]    s_data_i,
  input  logic                        flush_req_i,
  output logic                        fir_coef_shift_en_o,
  output logic [COEF_WIDTH-1:0]       fir_coef_in_o,
  output logic                        fir_run_o,
  output logic [DATA_IN_WIDTH-1:0]    fir_data_in_o,
  input  logic                        fir_done_i,
  output logic                        coef_loaded_o,
  output logic                        flushing_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAP_W = $clog2(ORDER);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(ORDER - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2, ST_WAIT = 2'd3} state_t;

  state_t                     state_q, state_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic                       coef_loaded_q, coef_loaded_d;
  logic                       load_pend_q, load_pend_d;
  logic                       shift_en_q, shift_en_d;
  logic [COEF_WIDTH-1:0]      coef_in_q, coef_in_d;
  logic                       run_q, run_d;
  logic [DATA_IN_WIDTH-1:0]   data_q, data_d;
  logic [DATA_IN_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       s_ready_q, s_ready_d;

  logic in_run_s, load_evt_s, go_load_s, enter_load_s, coef_acc_s, last_coef_s;
  logic flush_cont_s, flush_new_s, flush_sel_s, issue_zero_s, issue_sample_s, push_s, pop_s;

  // A pending load outranks any flush, and a flush outranks queued samples.
  assign in_run_s       = (state_q == ST_RUN);
  assign load_evt_s     = load_req_i | load_pend_q;
  assign go_load_s      = in_run_s & load_evt_s;
  assign enter_load_s   = go_load_s | ((state_q == ST_IDLE) & load_req_i);
  assign coef_acc_s     = coef_valid_i & (state_q == ST_LOAD);
  assign last_coef_s    = coef_acc_s & (tap_q == TAP_LAST);
  assign flush_sel_s    = flush_cont_s | flush_new_s;
  assign issue_zero_s   = in_run_s & ~load_evt_s & flush_sel_s;
  assign issue_sample_s = in_run_s & ~load_evt_s & ~flush_sel_s & (count_q != CNT_W'(0));
  assign push_s         = s_valid_i & s_ready_q;
  assign pop_s          = issue_sample_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = load_req_i ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = last_coef_s ? ST_RUN : ST_LOAD;
      ST_RUN: begin
        if (load_evt_s) begin
          state_d = ST_LOAD;
        end else if (issue_zero_s | issue_sample_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: state_d = fir_done_i ? ST_RUN : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tap_d         = tap_q;
    coef_loaded_d = coef_loaded_q;
    load_pend_d   = load_pend_q;
    coef_in_d     = coef_in_q;
    data_d        = data_q;
    count_d       = count_q;
    shift_en_d    = coef_acc_s;
    run_d         = issue_zero_s | issue_sample_s;
    wr_ptr_d      = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (enter_load_s) begin
      tap_d         = TAP_W'(0);
      coef_loaded_d = 1'b0;
      load_pend_d   = 1'b0;
    end else if (coef_acc_s) begin
      tap_d         = last_coef_s ? TAP_W'(0) : tap_q + TAP_W'(1);
      coef_loaded_d = last_coef_s ? 1'b1 : coef_loaded_q;
    end else if ((state_q == ST_WAIT) && load_req_i) begin
      load_pend_d = 1'b1;
    end else begin
      tap_d = tap_q;
    end
    if (coef_acc_s) begin
      coef_in_d = coef_data_i;
    end else begin
      coef_in_d = coef_in_q;
    end
    if (issue_sample_s) begin
      data_d = mem_q[rd_ptr_q];
    end else if (issue_zero_s) begin
      data_d = DATA_IN_WIDTH'(0);
    end else begin
      data_d = data_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Full flag is registered, so a same-cycle pop never reopens s_ready early.
    s_ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap_q         <= TAP_W'(0);
      coef_loaded_q <= 1'b0;
      load_pend_q   <= 1'b0;
      shift_en_q    <= 1'b0;
      coef_in_q     <= COEF_WIDTH'(0);
      run_q         <= 1'b0;
      data_q        <= DATA_IN_WIDTH'(0);
      wr_ptr_q      <= PTR_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      count_q       <= CNT_W'(0);
      s_ready_q     <= 1'b0;
    end else begin
      tap_q         <= tap_d;
      coef_loaded_q <= coef_loaded_d;
      load_pend_q   <= load_pend_d;
      shift_en_q    <= shift_en_d;
      coef_in_q     <= coef_in_d;
      run_q         <= run_d;
      data_q        <= data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      s_ready_q     <= s_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

`ifdef FIR_FEED_FLUSH_EN
  localparam int FCNT_W = $clog2(ORDER + 1);
  logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic              flush_pend_q, flush_pend_d, flushing_q, flushing_d;

  assign flush_cont_s = (flush_cnt_q != FCNT_W'(0));
  assign flush_new_s  = flush_req_i | flush_pend_q;

  // flush_cnt holds the zeros still to issue after the one in flight.
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    flushing_d   = flushing_q;
    if (go_load_s) begin
      flush_cnt_d  = FCNT_W'(0);
      flush_pend_d = 1'b0;
    end else if (issue_zero_s) begin
      flush_cnt_d  = flush_cont_s ? flush_cnt_q - FCNT_W'(1) : FCNT_W'(ORDER - 1);
      flush_pend_d = 1'b0;
    end else if ((state_q == ST_WAIT) && flush_req_i && !flushing_q && !flush_cont_s) begin
      flush_pend_d = 1'b1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (issue_zero_s) begin
      flushing_d = 1'b1;
    end else if ((state_q == ST_WAIT) && fir_done_i) begin
      flushing_d = 1'b0;
    end else begin
      flushing_d = flushing_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q  <= FCNT_W'(0);
      flush_pend_q <= 1'b0;
      flushing_q   <= 1'b0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      flushing_q   <= flushing_d;
    end
  end

  assign flushing_o = flushing_q;
`else
  logic flush_unused_s;
  assign flush_unused_s = flush_req_i;
  assign flush_cont_s   = 1'b0;
  assign flush_new_s    = 1'b0;
  assign flushing_o     = 1'b0;
`endif

  assign coef_ready_o        = (state_q == ST_LOAD);
  assign s_ready_o           = s_ready_q;
  assign fir_coef_shift_en_o = shift_en_q;
  assign fir_coef_in_o       = coef_in_q;
  assign fir_run_o           = run_q;
  assign fir_data_in_o       = data_q;
  assign coef_loaded_o       = coef_loaded_q;
  assign fifo_count_o        = count_q;
endmodule

// File: tb/tb_fir_seq_feeder.sv
// Self-checking bench for fir_seq_feeder: directed sequences plus randomized traffic
// compared every cycle against a queue-based reference model of the sequencer rules.
module tb_fir_seq_feeder;
  localparam int ORD = 6;
  localparam int DEP = 4;
`ifdef FIR_FEED_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_WAIT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, load_req = 1'b0, coef_valid = 1'b0, s_valid = 1'b0, flush_req = 1'b0, fir_done = 1'b0;
  logic [7:0] coef_data = 8'h00, s_data = 8'h00;
  logic coef_ready_o, s_ready_o, fir_coef_shift_en_o, fir_run_o, coef_loaded_o, flushing_o;
  logic [7:0] fir_coef_in_o, fir_data_in_o;
  logic [2:0] fifo_count_o;

  fir_seq_feeder #(.DATA_IN_WIDTH(8), .COEF_WIDTH(8), .ORDER(ORD), .FIFO_DEPTH(DEP)) dut (
    .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .coef_valid_i(coef_valid),
    .coef_ready_o(coef_ready_o), .coef_data_i(coef_data), .s_valid_i(s_valid),
    .s_ready_o(s_ready_o), .s_data_i(s_data), .flush_req_i(flush_req),
    .fir_coef_shift_en_o(fir_coef_shift_en_o), .fir_coef_in_o(fir_coef_in_o),
    .fir_run_o(fir_run_o), .fir_data_in_o(fir_data_in_o), .fir_done_i(fir_done),
    .coef_loaded_o(coef_loaded_o), .flushing_o(flushing_o), .fifo_count_o(fifo_count_o)
  );

  int n_tests = 0, n_fail = 0, cyc = 0, n_runs = 0, last_run_cyc = 0, prev_run_cyc = 0;
  bit done_en = 1'b0;
  int done_lat = 4, done_cnt = 0;

  // Reference model state: a sample queue plus a handful of counters and flags.
  int m_mode = M_IDLE, m_taps = 0, m_fleft = 0;
  bit m_loaded = 0, m_lpend = 0, m_fpend = 0, m_flushing = 0, m_run = 0, m_shift = 0, m_sready = 0;
  logic [7:0] m_din = 8'h00, m_cin = 8'h00;
  logic [7:0] m_q[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit push, pop;
    logic [7:0] head;
    if (rst) begin
      m_mode = M_IDLE; m_taps = 0; m_fleft = 0; m_loaded = 0; m_lpend = 0; m_fpend = 0;
      m_flushing = 0; m_run = 0; m_shift = 0; m_sready = 0; m_din = 8'h00; m_cin = 8'h00;
      m_q.delete();
    end else begin
      push = s_valid && m_sready;
      pop = 0; m_run = 0; m_shift = 0;
      case (m_mode)
        M_IDLE: if (load_req) begin m_mode = M_LOAD; m_loaded = 0; m_taps = 0; m_lpend = 0; end
        M_LOAD: if (coef_valid) begin
          m_shift = 1; m_cin = coef_data; m_taps++;
          if (m_taps == ORD) begin m_loaded = 1; m_mode = M_RUN; m_taps = 0; end
        end
        M_RUN: begin
          if (load_req || m_lpend) begin
            m_mode = M_LOAD; m_loaded = 0; m_taps = 0; m_lpend = 0; m_fleft = 0; m_fpend = 0;
          end else if (FLUSH_EN && (m_fleft > 0 || flush_req || m_fpend)) begin
            if (m_fleft > 0) m_fleft--;
            else begin m_fleft = ORD - 1; m_fpend = 0; end
            m_run = 1; m_din = 8'h00; m_flushing = 1; m_mode = M_WAIT;
          end else if (m_q.size() > 0) begin
            m_run = 1; m_din = m_q[0]; pop = 1; m_mode = M_WAIT;
          end
        end
        M_WAIT: begin
          if (load_req) m_lpend = 1;
          if (FLUSH_EN && flush_req && !m_flushing && m_fleft == 0) m_fpend = 1;
          if (fir_done) begin m_mode = M_RUN; m_flushing = 0; end
        end
        default: m_mode = M_IDLE;
      endcase
      if (pop) head = m_q.pop_front();
      if (push) m_q.push_back(s_data);
      m_sready = (m_q.size() < DEP);
    end
  endtask

  // One clock: model advance at the edge, full output compare 1 time unit later, FIR responder.
  task automatic cycle();
    logic [24:0] act, exp;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    act = {fir_run_o, fir_data_in_o, fir_coef_shift_en_o, fir_coef_in_o, coef_ready_o,
           s_ready_o, coef_loaded_o, flushing_o, fifo_count_o};
    exp = {m_run, m_din, m_shift, m_cin, (m_mode == M_LOAD), m_sready, m_loaded, m_flushing,
           3'(m_q.size())};
    check($sformatf("cyc%0d outputs", cyc), 32'(act), 32'(exp));
    if (fir_run_o) begin prev_run_cyc = last_run_cyc; last_run_cyc = cyc; n_runs++; end
    if (done_cnt > 0) begin done_cnt--; fir_done = (done_cnt == 0); end
    else fir_done = 1'b0;
    if (fir_run_o && done_en) done_cnt = done_lat;
  endtask

  task automatic wait_run(input string name, input int max_cyc);
    int n = 0;
    do begin cycle(); n++; end while (!fir_run_o && n < max_cyc);
    check({name, " run seen"}, 32'(fir_run_o), 32'd1);
  endtask

  task automatic shift_coefs(input logic [7:0] base);
    for (int k = 0; k < ORD; k++) begin
      coef_valid = 1'b1; coef_data = base + 8'(k);
      cycle();
      check($sformatf("coef%0d shift", k), 32'({fir_coef_shift_en_o, fir_coef_in_o}), 32'({1'b1, base + 8'(k)}));
      check($sformatf("coef%0d loaded", k), 32'(coef_loaded_o), 32'(k == ORD - 1));
    end
    coef_valid = 1'b0;
  endtask

  task automatic push_sample(input logic [7:0] d);
    int n = 0;
    bit acc;
    s_valid = 1'b1; s_data = d;
    do begin acc = m_sready; cycle(); n++; end while (!acc && n < 20);
    s_valid = 1'b0;
    check("push accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_d[$];
    bit exp_f[$];
    int base;
    vecs[0] = '{8'h11, 8'h11, 3'd2};
    vecs[1] = '{8'h22, 8'h22, 3'd1};
    vecs[2] = '{8'h33, 8'h33, 3'd0};

    repeat (2) cycle();
    rst = 1'b0;
    check("reset outputs", 32'({fir_run_o, fir_data_in_o, fir_coef_shift_en_o, fir_coef_in_o, coef_ready_o,
          s_ready_o, coef_loaded_o, flushing_o, fifo_count_o}), 32'd0);
    cycle();

    // Samples queue in IDLE, then a coefficient load releases them one per done.
    for (int i = 0; i < 3; i++) push_sample(vecs[i].din);
    check("count after 3 pushes", 32'(fifo_count_o), 32'd3);
    check("no run before load", 32'(n_runs), 32'd0);
    load_req = 1'b1; cycle(); load_req = 1'b0;
    shift_coefs(8'd1);
    done_en = 1'b1; done_lat = 4;
    for (int i = 0; i < 3; i++) begin
      wait_run($sformatf("vec%0d", i), 20);
      check($sformatf("vec%0d data", i), 32'(fir_data_in_o), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d count", i), 32'(fifo_count_o), 32'(vecs[i].exp_cnt));
      if (i > 0) check($sformatf("vec%0d spacing", i), 32'(last_run_cyc - prev_run_cyc), 32'(done_lat + 2));
    end
    repeat (8) cycle();

    // Backpressure: one sample outstanding without done, FIFO fills, fifth is held.
    done_en = 1'b0;
    push_sample(8'hB0);
    for (int i = 0; i < 4; i++) push_sample(8'hA0 + 8'(i));
    check("full s_ready", 32'(s_ready_o), 32'd0);
    check("full count", 32'(fifo_count_o), 32'd4);
    s_valid = 1'b1; s_data = 8'hA4;
    repeat (3) cycle();
    check("held s_ready", 32'(s_ready_o), 32'd0);
    check("held count", 32'(fifo_count_o), 32'd4);
    fir_done = 1'b1; cycle();
    cycle();
    check("pop run", 32'({fir_run_o, fir_data_in_o}), 32'({1'b1, 8'hA0}));
    check("s_ready after pop", 32'(s_ready_o), 32'd1);
    cycle(); s_valid = 1'b0;
    check("count after refill", 32'(fifo_count_o), 32'd4);

    // Load request during WAIT is deferred until done, then preempts queued samples.
    load_req = 1'b1; cycle(); load_req = 1'b0;
    repeat (2) cycle();
    fir_done = 1'b1; cycle();
    cycle();
    check("pending load no run", 32'(fir_run_o), 32'd0);
    check("pending load coef_ready", 32'(coef_ready_o), 32'd1);
    check("pending load loaded", 32'(coef_loaded_o), 32'd0);
    shift_coefs(8'h31);
    done_en = 1'b1; done_lat = 2;
    for (int i = 1; i < 5; i++) begin
      wait_run($sformatf("after load %0d", i), 20);
      check($sformatf("after load %0d data", i), 32'(fir_data_in_o), 32'(8'hA0 + 8'(i)));
    end
    repeat (6) cycle();

    // Reset in the middle of a load forces a complete reload.
    load_req = 1'b1; cycle(); load_req = 1'b0;
    coef_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin coef_data = 8'h41 + 8'(k); cycle(); end
    coef_valid = 1'b0; rst = 1'b1; cycle(); rst = 1'b0;
    check("mid-load reset outputs", 32'({fir_run_o, fir_data_in_o, fir_coef_shift_en_o, fir_coef_in_o,
          coef_ready_o, s_ready_o, coef_loaded_o, flushing_o, fifo_count_o}), 32'd0);
    cycle();
    push_sample(8'hC0); push_sample(8'hC1);
    base = n_runs;
    repeat (10) cycle();
    check("no issue after reset", 32'(n_runs - base), 32'd0);
    load_req = 1'b1; cycle(); load_req = 1'b0;
    shift_coefs(8'h51);

    // Flush request on the first RUN cycle with two samples queued.
    flush_req = 1'b1; done_lat = 3;
    if (FLUSH_EN) for (int i = 0; i < ORD; i++) begin exp_d.push_back(8'h00); exp_f.push_back(1'b1); end
    exp_d.push_back(8'hC0); exp_f.push_back(1'b0);
    exp_d.push_back(8'hC1); exp_f.push_back(1'b0);
    for (int i = 0; i < exp_d.size(); i++) begin
      wait_run($sformatf("flush seq %0d", i), 20);
      flush_req = 1'b0;
      check($sformatf("flush seq %0d data", i), 32'(fir_data_in_o), 32'(exp_d[i]));
      check($sformatf("flush seq %0d flushing", i), 32'(flushing_o), 32'(exp_f[i]));
    end
    base = n_runs;
    repeat (10) cycle();
    check("no extra issue", 32'(n_runs - base), 32'd0);

    // Randomized traffic, including spurious done pulses and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      load_req   = ($urandom_range(0, 39) == 0);
      coef_valid = ($urandom_range(0, 1) == 1);
      coef_data  = 8'($urandom);
      s_valid    = ($urandom_range(0, 1) == 1);
      s_data     = 8'($urandom);
      flush_req  = ($urandom_range(0, 29) == 0);
      done_lat   = $urandom_range(1, 6);
      cycle();
      fir_done = fir_done | ($urandom_range(0, 19) == 0);
    end
    rst = 1'b0; load_req = 1'b0; coef_valid = 1'b0; s_valid = 1'b0; flush_req = 1'b0;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
